mesi_bus_arbiter: RTL
=====================

Name: mesi_bus_arbiter

Overview:
- Shares the single snoop bus between N MESI cache-line controllers and sequences each coherence transaction: arbitrate, broadcast, collect snoop, write-back or memory fetch, complete.
- For the granted node it drives the emitter select, which is that node's Controle. All other nodes act as listeners.
- It drives the broadcast event, and returns the "other sharer" indication that the requester uses as CPU_event bit 4.

Parameters:
- N, 4, number of cache controllers (2..8).
- AW, 8, bus address/tag width.

Ports:
- CLK in 1: single clock, rising edge.
- CLR in 1: reset, asynchronous, active-high.
- req in N: per-node transaction request; held high until that node's done.
- req_op in 3*N: per-node bus opcode; node i uses bits [3i+2:3i].
- req_addr in AW*N: per-node line address; node i uses slice i.
- gnt out N: one-hot grant to the owning node.
- emitter out N: one-hot Controle per node, equal to gnt. 0 means listener.
- bus_valid out 1: broadcast strobe.
- bus_op out 3: broadcast opcode.
- bus_addr out AW: broadcast address.
- bus_src out 3: index of the emitting node.
- snoop_shared in N: listener holds the line in S or E.
- snoop_wb in N: listener holds the line in M, meaning write-back plus abort of the memory access.
- mem_req out 1: memory request.
- mem_we out 1: 1 = write-back, 0 = line fill.
- mem_ack in 1: single-cycle memory completion.
- done out N: one-cycle completion pulse to the requester.
- shared_out out 1: another node holds a copy; valid while done is high.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. The internal round-robin pointer resets to N-1, so node 0 has first priority.
- CLR asserted mid-transaction aborts it immediately: state IDLE, all outputs 0, no done pulse.
- Opcodes: RM=001, WM=010, WB=011, INV=100. Any other value follows the INV path.
- FSM states: IDLE, BCAST, SNOOP, WB, FILL, DONE.
- IDLE:
  - If any req is high, the round-robin winner is the first requester after the pointer, wrapping modulo N.
  - gnt/emitter are loaded, bus_op/bus_addr/bus_src are latched from the winner, and the pointer is updated to the winner.
  - Next state is BCAST.
- BCAST: exactly 1 cycle with bus_valid=1. bus_op/bus_addr/bus_src are held stable until DONE exits.
- SNOOP: exactly 1 cycle.
  - Sample snoop_shared and snoop_wb, masked with ~gnt so the requester's own bits are ignored.
  - Latch shared_flag = |(masked shared | masked wb).
  - Next state by priority:
    - any masked wb → WB;
    - else op is RM or WM → FILL;
    - else → DONE.
- WB: mem_req=1, mem_we=1 until mem_ack. Then go to DONE; the fill is aborted because the write-back supplies the line.
- FILL: mem_req=1, mem_we=0 until mem_ack. Then go to DONE.
- DONE: 1 cycle.
  - done[winner]=1 and shared_out=shared_flag.
  - gnt and emitter stay asserted through DONE and are cleared on entry to IDLE.
- mem_req deasserts in the cycle after mem_ack is sampled. mem_ack outside WB/FILL is ignored.
- Latency for INV with no snoop hit: req sampled at edge k; BCAST in cycle k+1, SNOOP k+2, done pulse in k+3, IDLE k+4. The minimum turnaround between grants is 4 cycles.
- req dropping mid-transaction has no effect; the transaction completes.
- Requests arriving during a transaction wait for IDLE.
- Simultaneous requests are resolved by round-robin only; no node is granted twice while another requester is waiting.
- A single persistent requester is re-granted on every IDLE visit.

Decomposition:
- Package mesi_bus_pkg:
  - opcode constants OP_RM, OP_WM, OP_WB, OP_INV;
  - FSM state encoding (3 bits);
  - snoop-response bit meanings shared with the cache-line block.
- Sub-module rr_arbiter (N): inputs req and pointer; outputs one-hot winner and winner index. Purely combinational; it is instantiated once and the pointer register lives in the top.

Test Plan:
- Reset: CLR pulse mid-FILL → all outputs 0 same cycle (async), no done; next req=0001 → node 0 granted.
- Single INV: node 2 req, op=100, addr=0x5A, no snoop → bus_valid one cycle with bus_op=100, bus_addr=0x5A, bus_src=2; done[2] 3 cycles after req sample; mem_req never high; shared_out=0.
- RM with sharer: node 0 RM addr=0x11, snoop_shared=0100 → FILL with mem_we=0; mem_ack after 3 cycles → done[0] with shared_out=1.
- RM with modified owner: node 1 RM, snoop_wb=1000 → WB with mem_we=1, then DONE without FILL; shared_out=1.
- Round-robin: req=1111 held continuously → grant order 0,1,2,3,0.
- Self-mask: node 3 WM with snoop_wb=1000 and snoop_shared=1000 (its own bits) → FILL path, not WB; shared_out=0.

Source files
------------

// File: rtl/mesi_bus_pkg.sv
// Shared definitions for the MESI snoop-bus arbiter: opcodes, FSM encoding and
// the per-listener snoop response as seen by the cache-line controllers.
package mesi_bus_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned SRC_W = 3;

    localparam logic [OP_W-1:0] OP_RM  = 3'b001;
    localparam logic [OP_W-1:0] OP_WM  = 3'b010;
    localparam logic [OP_W-1:0] OP_WB  = 3'b011;
    localparam logic [OP_W-1:0] OP_INV = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BCAST = 3'd1,
        ST_SNOOP = 3'd2,
        ST_WB    = 3'd3,
        ST_FILL  = 3'd4,
        ST_DONE  = 3'd5
    } bus_state_e;

    // shared: listener holds the line in S or E; wb: listener holds it in M
    typedef struct packed {
        logic wb;
        logic shared;
    } snoop_rsp_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [SRC_W-1:0] src;
    } bus_hdr_t;

    // Read/write misses need the line from memory unless a modified copy supplies it
    function automatic logic op_needs_fill(input logic [OP_W-1:0] op);
        case (op)
            OP_RM, OP_WM:  return 1'b1;
            OP_WB, OP_INV: return 1'b0;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_c,
    output logic [IW-1:0] idx_c
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        win_c = '0;
        idx_c = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IW'((32'(ptr) + off) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                win_c[cand] = 1'b1;
                idx_c       = cand;
            end
        end
    end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Snoop-bus owner for N MESI controllers: grants one requester at a time and walks
// it through broadcast, snoop collection, optional write-back or fill, and completion.
module mesi_bus_arbiter
    import mesi_bus_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 8
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic [N-1:0]        req,
    input  logic [OP_W*N-1:0]   req_op,
    input  logic [AW*N-1:0]     req_addr,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        emitter,
    output logic                bus_valid,
    output logic [OP_W-1:0]     bus_op,
    output logic [AW-1:0]       bus_addr,
    output logic [SRC_W-1:0]    bus_src,
    input  logic [N-1:0]        snoop_shared,
    input  logic [N-1:0]        snoop_wb,
    output logic                mem_req,
    output logic                mem_we,
    input  logic                mem_ack,
    output logic [N-1:0]        done,
    output logic                shared_out
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    bus_state_e     state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic           shared_flag_q, shared_flag_d;
    bus_hdr_t       hdr_q, hdr_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [N-1:0]   gnt_d, done_d;
    logic           bus_valid_d, mem_req_d, mem_we_d, shared_out_d;

    logic [N-1:0]     win_c;
    logic [IW-1:0]    win_idx_c;
    logic [OP_W-1:0]  win_op_c;
    logic [AW-1:0]    win_addr_c;
    snoop_rsp_t [N-1:0] snp_c;
    logic             any_wb_c, any_copy_c;

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_rr (
        .req   (req),
        .ptr   (rr_ptr_q),
        .win_c (win_c),
        .idx_c (win_idx_c)
    );

    // Payload of the winning node
    always_comb begin
        win_op_c   = '0;
        win_addr_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (win_c[i]) begin
                win_op_c   = req_op[OP_W*i +: OP_W];
                win_addr_c = req_addr[AW*i +: AW];
            end
        end
    end

    // Listener responses; the emitter's own snoop bits never count
    always_comb begin
        snp_c      = '0;
        any_wb_c   = 1'b0;
        any_copy_c = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            snp_c[i].shared = snoop_shared[i] & ~gnt[i];
            snp_c[i].wb     = snoop_wb[i] & ~gnt[i];
            any_wb_c        = any_wb_c | snp_c[i].wb;
            any_copy_c      = any_copy_c | snp_c[i].wb | snp_c[i].shared;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        shared_flag_d = shared_flag_q;
        hdr_d         = hdr_q;
        addr_d        = addr_q;
        gnt_d         = gnt;
        bus_valid_d   = 1'b0;
        mem_req_d     = mem_req;
        mem_we_d      = mem_we;
        done_d        = '0;
        shared_out_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d       = ST_BCAST;
                    gnt_d         = win_c;
                    bus_valid_d   = 1'b1;
                    hdr_d.op      = win_op_c;
                    hdr_d.src     = SRC_W'(win_idx_c);
                    addr_d        = win_addr_c;
                    rr_ptr_d      = win_idx_c;
                    shared_flag_d = 1'b0;
                end
            end
            ST_BCAST: begin
                state_d = ST_SNOOP;
            end
            ST_SNOOP: begin
                shared_flag_d = any_copy_c;
                if (any_wb_c) begin
                    state_d   = ST_WB;
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                end else if (op_needs_fill(hdr_q.op)) begin
                    state_d   = ST_FILL;
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b0;
                end else begin
                    state_d      = ST_DONE;
                    done_d       = gnt;
                    shared_out_d = any_copy_c;
                end
            end
            // A write-back delivers the line, so it replaces the fill entirely
            ST_WB, ST_FILL: begin
                if (mem_ack) begin
                    state_d      = ST_DONE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    done_d       = gnt;
                    shared_out_d = shared_flag_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                hdr_d   = '0;
                addr_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= IW'(N - 1);
            shared_flag_q <= 1'b0;
            hdr_q         <= '0;
            addr_q        <= '0;
            gnt           <= '0;
            emitter       <= '0;
            bus_valid     <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            done          <= '0;
            shared_out    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            shared_flag_q <= shared_flag_d;
            hdr_q         <= hdr_d;
            addr_q        <= addr_d;
            gnt           <= gnt_d;
            emitter       <= gnt_d;
            bus_valid     <= bus_valid_d;
            mem_req       <= mem_req_d;
            mem_we        <= mem_we_d;
            done          <= done_d;
            shared_out    <= shared_out_d;
        end
    end

    assign bus_op   = hdr_q.op;
    assign bus_src  = hdr_q.src;
    assign bus_addr = addr_q;

endmodule
